// File: rtl/acc_pkg.sv
// Shared definitions for the baseline-removing unit accumulator:
// FSM encoding, default widths and the accumulator guard-bit width.
package acc_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_ACC_W   = 24;
  localparam int DEF_LEN_W   = 8;
  // One extra carry bit on the running sum reveals overflow before clamping.
  localparam int SAT_GUARD_W = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

endpackage

// File: rtl/acc_sat_sub.sv
// Registered baseline subtract with floor at zero; zero-extends to OUT_W.
// Flush drops the in-flight sample so nothing leaks past a run stop.
module acc_sat_sub #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 24
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              vld_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] base_i,
  output logic              vld_o,
  output logic [OUT_W-1:0]  diff_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_o  <= 1'b0;
      diff_o <= '0;
    end else if (flush_i) begin
      vld_o  <= 1'b0;
      diff_o <= '0;
    end else begin
      vld_o <= vld_i;
      if (vld_i) begin
        diff_o <= (data_i > base_i) ? OUT_W'(data_i - base_i) : '0;
      end
    end
  end

endmodule

// File: rtl/acc_filter_unit.sv
// Baseline-removed unit accumulator with hysteretic threshold compare.
// Pipeline: stage0 count/latch, stage1 subtract, stage2 accumulate, then outputs.
//   state | meaning
//   IDLE  | laser off, pipeline flushed, waiting for laser_start_i rise
//   ACCUM | summing samples into back-to-back units
module acc_filter_unit
  import acc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              laser_start_i,
  input  logic              adc_vld_i,
  input  logic [DATA_W-1:0] adc_data_i,
  input  logic [DATA_W-1:0] baseline_i,
  input  logic [LEN_W-1:0]  unit_len_i,
  input  logic [ACC_W-1:0]  acc_thresh_i,
  input  logic [ACC_W-1:0]  acc_hyst_i,
  output logic              filter_unit_vld_o,
  output logic              filter_acc_result_o,
  output logic [ACC_W-1:0]  unit_sum_o,
  output logic [31:0]       unit_cnt_o,
  output logic              acc_sat_o
);

  localparam int SUM_W = ACC_W + SAT_GUARD_W;

  state_t             r_state;
  logic               r_start_q;
  logic [LEN_W-1:0]   r_cnt, r_len;
  logic [ACC_W-1:0]   r_thr0, r_hyst0, r_thr2, r_lo2, r_acc;
  logic               r_last1, r_last2, r_first2, r_usat;
  logic               w_rise, w_take, w_first0, w_last0, w_vld1;
  logic [LEN_W-1:0]   w_len_raw, w_len, w_len_m1;
  logic [ACC_W-1:0]   w_d1, w_base, w_lo0;
  logic [SUM_W-1:0]   w_sum;

  assign w_rise    = laser_start_i & ~r_start_q;
  assign w_take    = adc_vld_i & laser_start_i & ((r_state == ACCUM) | w_rise);
  assign w_first0  = (r_cnt == '0);
  // A unit's first sample uses the live length, later samples the latched one.
  assign w_len_raw = w_first0 ? unit_len_i : r_len;
  assign w_len     = (w_len_raw == '0) ? LEN_W'(1) : w_len_raw;
  assign w_len_m1  = w_len - LEN_W'(1);
  assign w_last0   = (r_cnt == w_len_m1);
  assign w_lo0     = (r_thr0 > r_hyst0) ? (r_thr0 - r_hyst0) : '0;
  assign w_base    = r_first2 ? '0 : r_acc;
  assign w_sum     = SUM_W'(w_base) + SUM_W'(w_d1);

  acc_sat_sub #(.DATA_W(DATA_W), .OUT_W(ACC_W)) u_sub (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (~laser_start_i),
    .vld_i   (w_take),
    .data_i  (adc_data_i),
    .base_i  (baseline_i),
    .vld_o   (w_vld1),
    .diff_o  (w_d1)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state             <= IDLE;
      r_start_q           <= 1'b0;
      r_cnt               <= '0;
      r_len               <= '0;
      r_thr0              <= '0;
      r_hyst0             <= '0;
      r_thr2              <= '0;
      r_lo2               <= '0;
      r_acc               <= '0;
      r_last1             <= 1'b0;
      r_last2             <= 1'b0;
      r_first2            <= 1'b1;
      r_usat              <= 1'b0;
      filter_unit_vld_o   <= 1'b0;
      filter_acc_result_o <= 1'b0;
      unit_sum_o          <= '0;
      unit_cnt_o          <= '0;
      acc_sat_o           <= 1'b0;
    end else begin
      r_start_q         <= laser_start_i;
      filter_unit_vld_o <= 1'b0;
      case (r_state)
        IDLE: if (w_rise) begin
          r_state             <= ACCUM;
          unit_cnt_o          <= '0;
          acc_sat_o           <= 1'b0;
          filter_acc_result_o <= 1'b0;
        end
        ACCUM: if (!laser_start_i) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (!laser_start_i) begin
        r_cnt               <= '0;
        r_last1             <= 1'b0;
        r_last2             <= 1'b0;
        r_first2            <= 1'b1;
        r_acc               <= '0;
        r_usat              <= 1'b0;
        filter_acc_result_o <= 1'b0;
      end else begin
        if (w_take) begin
          r_cnt <= w_last0 ? '0 : r_cnt + LEN_W'(1);
          if (w_first0) begin
            r_len   <= unit_len_i;
            r_thr0  <= acc_thresh_i;
            r_hyst0 <= acc_hyst_i;
          end
        end
        r_last1 <= w_take & w_last0;
        // Thresholds travel with the unit so the next unit may relatch early.
        if (w_vld1) begin
          r_acc    <= w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
          r_usat   <= (r_usat & ~r_first2) | w_sum[ACC_W];
          r_first2 <= r_last1;
          if (r_last1) begin
            r_thr2 <= r_thr0;
            r_lo2  <= w_lo0;
          end
        end
        r_last2 <= w_vld1 & r_last1;
        if (r_last2) begin
          filter_unit_vld_o <= 1'b1;
          unit_sum_o        <= r_acc;
          unit_cnt_o        <= unit_cnt_o + 32'd1;
          if (r_usat) acc_sat_o <= 1'b1;
          if (r_acc >= r_thr2) filter_acc_result_o <= 1'b1;
          else if (r_acc < r_lo2) filter_acc_result_o <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_acc_filter_unit.sv
// Directed bench for acc_filter_unit; ACC_W is narrowed to 20 so that a
// 255-sample unit of full-scale samples actually saturates the accumulator.
module tb_acc_filter_unit;

  localparam int DW = 16;
  localparam int AW = 20;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          laser, adc_vld;
  logic [DW-1:0] adc_data, base;
  logic [LW-1:0] len;
  logic [AW-1:0] thr, hyst;
  logic          u_vld, res, sat;
  logic [AW-1:0] sum;
  logic [31:0]   cnt;
  int            n_cmp = 0;
  int            n_bad = 0;

  always #5 clk = ~clk;

  acc_filter_unit #(.DATA_W(DW), .ACC_W(AW), .LEN_W(LW)) dut (
    .clk_i               (clk),
    .rst_n_i             (rst_n),
    .laser_start_i       (laser),
    .adc_vld_i           (adc_vld),
    .adc_data_i          (adc_data),
    .baseline_i          (base),
    .unit_len_i          (len),
    .acc_thresh_i        (thr),
    .acc_hyst_i          (hyst),
    .filter_unit_vld_o   (u_vld),
    .filter_acc_result_o (res),
    .unit_sum_o          (sum),
    .unit_cnt_o          (cnt),
    .acc_sat_o           (sat)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d);
    adc_vld  = v;
    adc_data = d;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; laser = 1'b0; adc_vld = 1'b0; adc_data = '0;
    base = '0; len = '0; thr = '0; hyst = '0;
    #13;
    n_cmp++;
    if ({u_vld, res, sum, cnt, sat} !== '0) begin
      n_bad++; $display("FAIL reset_outputs got %h exp 0", {u_vld, res, sum, cnt, sat});
    end
    rst_n = 1'b1;
    step();
    step();
  endtask

  task automatic test_basic();
    base = 16'd100; len = 8'd4; thr = 20'd1000; hyst = '0;
    laser = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b1, 16'd350);
    drive(1'b0, '0);
    n_cmp++;
    if (u_vld !== 1'b0) begin n_bad++; $display("FAIL basic_early_vld got %b exp 0", u_vld); end
    drive(1'b0, '0);
    n_cmp++;
    if (u_vld !== 1'b1) begin n_bad++; $display("FAIL basic_vld got %b exp 1", u_vld); end
    n_cmp++;
    if (sum !== 20'd1000) begin n_bad++; $display("FAIL basic_sum got %0d exp 1000", sum); end
    n_cmp++;
    if (res !== 1'b1) begin n_bad++; $display("FAIL basic_result got %b exp 1", res); end
    n_cmp++;
    if (cnt !== 32'd1) begin n_bad++; $display("FAIL basic_cnt got %0d exp 1", cnt); end
    drive(1'b0, '0);
    n_cmp++;
    if (u_vld !== 1'b0) begin n_bad++; $display("FAIL basic_pulse_width got %b exp 0", u_vld); end
  endtask

  task automatic test_hysteresis();
    int   s_a[6]   = '{300, 200, 150, 100, 499, 250};
    int   s_b[6]   = '{300, 200, 150, 199, 0, 250};
    logic e_res[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    base = '0; len = 8'd2; thr = 20'd500; hyst = 20'd200;
    for (int u = 0; u < 6; u++) begin
      drive(1'b1, DW'(s_a[u]));
      drive(1'b1, DW'(s_b[u]));
      drive(1'b0, '0);
      drive(1'b0, '0);
      n_cmp++;
      if (u_vld !== 1'b1) begin n_bad++; $display("FAIL hyst_vld unit %0d got %b exp 1", u, u_vld); end
      n_cmp++;
      if (res !== e_res[u]) begin
        n_bad++; $display("FAIL hyst_result unit %0d sum %0d got %b exp %b", u, sum, res, e_res[u]);
      end
      n_cmp++;
      if (cnt !== 32'(u + 2)) begin n_bad++; $display("FAIL hyst_cnt unit %0d got %0d exp %0d", u, cnt, u + 2); end
    end
  endtask

  task automatic test_saturation();
    laser = 1'b0;
    drive(1'b0, '0);
    laser = 1'b1; base = '0; len = 8'd255;
    for (int i = 0; i < 255; i++) drive(1'b1, 16'hFFFF);
    drive(1'b0, '0);
    drive(1'b0, '0);
    n_cmp++;
    if (sum !== 20'hFFFFF) begin n_bad++; $display("FAIL sat_sum got %h exp fffff", sum); end
    n_cmp++;
    if (sat !== 1'b1) begin n_bad++; $display("FAIL sat_flag got %b exp 1", sat); end
    n_cmp++;
    if (cnt !== 32'd1) begin n_bad++; $display("FAIL sat_cnt got %0d exp 1", cnt); end
    len = 8'd16;
    for (int i = 0; i < 16; i++) drive(1'b1, 16'hFFFF);
    drive(1'b0, '0);
    drive(1'b0, '0);
    n_cmp++;
    if (sum !== 20'hFFFF0) begin n_bad++; $display("FAIL nosat_sum got %h exp ffff0", sum); end
    n_cmp++;
    if (sat !== 1'b1) begin n_bad++; $display("FAIL sat_sticky got %b exp 1", sat); end
    laser = 1'b0;
    drive(1'b0, '0);
    n_cmp++;
    if (res !== 1'b0) begin n_bad++; $display("FAIL stop_result got %b exp 0", res); end
    n_cmp++;
    if (sat !== 1'b1) begin n_bad++; $display("FAIL sat_hold_idle got %b exp 1", sat); end
    laser = 1'b1;
    drive(1'b0, '0);
    n_cmp++;
    if (sat !== 1'b0) begin n_bad++; $display("FAIL sat_clear_on_rise got %b exp 0", sat); end
    n_cmp++;
    if (cnt !== 32'd0) begin n_bad++; $display("FAIL cnt_clear_on_rise got %0d exp 0", cnt); end
  endtask

  task automatic test_abort();
    logic seen;
    base = '0; thr = 20'd10; hyst = '0; len = 8'd8;
    for (int i = 0; i < 8; i++) drive(1'b1, 16'd5);
    drive(1'b0, '0);
    drive(1'b0, '0);
    n_cmp++;
    if ({u_vld, res, sum, cnt} !== {1'b1, 1'b1, 20'd40, 32'd1}) begin
      n_bad++; $display("FAIL abort_setup got vld %b res %b sum %0d cnt %0d exp 1 1 40 1", u_vld, res, sum, cnt);
    end
    for (int i = 0; i < 5; i++) drive(1'b1, 16'd5);
    laser = 1'b0;
    drive(1'b0, '0);
    n_cmp++;
    if ({u_vld, res} !== 2'b00) begin n_bad++; $display("FAIL abort_outputs got vld %b res %b exp 0 0", u_vld, res); end
    n_cmp++;
    if ({sum, cnt} !== {20'd40, 32'd1}) begin
      n_bad++; $display("FAIL abort_hold got sum %0d cnt %0d exp 40 1", sum, cnt);
    end
    drive(1'b0, '0);
    laser = 1'b1;
    drive(1'b0, '0);
    n_cmp++;
    if (cnt !== 32'd0) begin n_bad++; $display("FAIL abort_cnt_restart got %0d exp 0", cnt); end
    seen = 1'b0;
    for (int i = 0; i < 7; i++) begin drive(1'b1, 16'd1); seen |= u_vld; end
    for (int i = 0; i < 3; i++) begin drive(1'b0, '0); seen |= u_vld; end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_partial_vld got %b exp 0", seen); end
    drive(1'b1, 16'd1);
    drive(1'b0, '0);
    drive(1'b0, '0);
    n_cmp++;
    if ({u_vld, res, sum, cnt} !== {1'b1, 1'b0, 20'd8, 32'd1}) begin
      n_bad++; $display("FAIL abort_fresh_unit got vld %b res %b sum %0d cnt %0d exp 1 0 8 1", u_vld, res, sum, cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic e_vld;
    base = 16'd1000; thr = 20'd10; hyst = '0;
    for (int s = 1; s <= 14; s++) begin
      len = (s <= 6) ? 8'd1 : 8'd3;
      drive(s <= 12, (s <= 6) ? 16'd500 : 16'd1010);
      e_vld = (s >= 3 && s <= 8) || s == 11 || s == 14;
      n_cmp++;
      if (u_vld !== e_vld) begin n_bad++; $display("FAIL b2b_vld step %0d got %b exp %b", s, u_vld, e_vld); end
      if (s == 8) begin
        n_cmp++;
        if ({sum, res, cnt} !== {20'd0, 1'b0, 32'd7}) begin
          n_bad++; $display("FAIL b2b_len1 got sum %0d res %b cnt %0d exp 0 0 7", sum, res, cnt);
        end
      end
      if (s == 11) begin
        n_cmp++;
        if ({sum, res, cnt} !== {20'd30, 1'b1, 32'd8}) begin
          n_bad++; $display("FAIL b2b_len3 got sum %0d res %b cnt %0d exp 30 1 8", sum, res, cnt);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic seen;
    base = '0; len = 8'd4; thr = 20'd10;
    drive(1'b1, 16'd7);
    drive(1'b1, 16'd7);
    adc_vld = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({u_vld, res, sum, cnt, sat} !== '0) begin
      n_bad++; $display("FAIL async_reset got vld %b res %b sum %0d cnt %0d sat %b exp all 0", u_vld, res, sum, cnt, sat);
    end
    #2;
    rst_n = 1'b1;
    step();
    seen = 1'b0;
    drive(1'b1, 16'd7);
    drive(1'b1, 16'd7);
    for (int i = 0; i < 4; i++) begin drive(1'b0, '0); seen |= u_vld; end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL post_reset_spurious_vld got %b exp 0", seen); end
    drive(1'b1, 16'd7);
    drive(1'b1, 16'd7);
    drive(1'b0, '0);
    drive(1'b0, '0);
    n_cmp++;
    if ({u_vld, sum, cnt} !== {1'b1, 20'd28, 32'd1}) begin
      n_bad++; $display("FAIL post_reset_unit got vld %b sum %0d cnt %0d exp 1 28 1", u_vld, sum, cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hysteresis();
    test_saturation();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
